vram_arb: RTL and testbench

- Single-port VRAM access arbiter and sequencer.
- Shares the one 64K x 16 VRAM port between three requesters: video scanout, the CPU register interface and the blitter.
- Drives the VRAM sel/wr_en/address/data_in pins from registers.
- Routes the returned data_out word back to whichever requester issued the read.

---
 rtl/vram_arb.sv | 69 ++++++
 tb/tb_vram_arb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vram_arb.sv
// vram_arb: single-port VRAM arbiter (video > CPU/blitter) with 2-cycle tagged read return.
// Define VRAM_ARB_RR_EN for CPU/blitter round-robin; default is fixed CPU-over-blitter priority.
module vram_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_sel,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_rd_valid,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rd_valid,
  input  logic              blit_req,
  input  logic              blit_wr,
  input  logic [ADDR_W-1:0] blit_addr,
  input  logic [DATA_W-1:0] blit_wdata,
  output logic              blit_ack,
  output logic              blit_rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              vram_sel,
  output logic              vram_wr_en,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_data_out
);
  localparam logic [1:0] T_NONE = 2'd0, T_VID = 2'd1, T_CPU = 2'd2, T_BLIT = 2'd3;
  logic       cpu_win;
  logic [1:0] tag_issue, tag_data;
`ifdef VRAM_ARB_RR_EN
  logic ptr;
  // ptr = 1 favours the blitter; it flips to the loser after every CPU/blitter grant
  always_ff @(posedge clk)
    if (reset) ptr <= 1'b0;
    else if (cpu_ack | blit_ack) ptr <= cpu_ack;
  assign cpu_win = cpu_req & (~blit_req | ~ptr);
`else
  assign cpu_win = cpu_req;
`endif
  assign cpu_ack  = ~vid_sel & cpu_win;
  assign blit_ack = ~vid_sel & ~cpu_win & blit_req;
  always_ff @(posedge clk)
    if (reset) begin
      vram_sel   <= 1'b0;
      vram_wr_en <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      tag_issue  <= T_NONE;
      tag_data   <= T_NONE;
      rd_data    <= '0;
    end else begin
      vram_sel   <= vid_sel | cpu_ack | blit_ack;
      vram_wr_en <= (cpu_ack & cpu_wr) | (blit_ack & blit_wr);
      vram_addr  <= vid_sel ? vid_addr : cpu_ack ? cpu_addr : blit_ack ? blit_addr : vram_addr;
      vram_wdata <= (cpu_ack & cpu_wr) ? cpu_wdata : (blit_ack & blit_wr) ? blit_wdata : vram_wdata;
      tag_issue  <= vid_sel ? T_VID : (cpu_ack & ~cpu_wr) ? T_CPU :
                    (blit_ack & ~blit_wr) ? T_BLIT : T_NONE;
      tag_data   <= tag_issue;
      // capture only for reads so rd_data holds between valid pulses
      if (tag_issue != T_NONE) rd_data <= vram_data_out;
    end
  assign vid_rd_valid  = tag_data == T_VID;
  assign cpu_rd_valid  = tag_data == T_CPU;
  assign blit_rd_valid = tag_data == T_BLIT;
endmodule

// File: tb/tb_vram_arb.sv
// tb_vram_arb: directed + random checks of vram_arb against a per-cycle grant/memory reference model.
module tb_vram_arb;
  logic        clk = 1'b0, reset = 1'b1;
  logic        vid_sel = 1'b0, cpu_req = 1'b0, cpu_wr = 1'b0, blit_req = 1'b0, blit_wr = 1'b0;
  logic [15:0] vid_addr = '0, cpu_addr = '0, cpu_wdata = '0, blit_addr = '0, blit_wdata = '0;
  logic        vid_rd_valid, cpu_ack, cpu_rd_valid, blit_ack, blit_rd_valid;
  logic        vram_sel, vram_wr_en;
  logic [15:0] rd_data, vram_addr, vram_wdata, vram_data_out;
  logic [15:0] mem [65536];

  vram_arb dut (
    .clk(clk), .reset(reset),
    .vid_sel(vid_sel), .vid_addr(vid_addr), .vid_rd_valid(vid_rd_valid),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rd_valid(cpu_rd_valid),
    .blit_req(blit_req), .blit_wr(blit_wr), .blit_addr(blit_addr), .blit_wdata(blit_wdata),
    .blit_ack(blit_ack), .blit_rd_valid(blit_rd_valid),
    .rd_data(rd_data), .vram_sel(vram_sel), .vram_wr_en(vram_wr_en),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_data_out(vram_data_out)
  );

  always #5 clk = ~clk;

  // the VRAM itself: asynchronous read, write committed on the clock edge
  assign vram_data_out = mem[vram_addr];
  always @(posedge clk) if (vram_sel && vram_wr_en) mem[vram_addr] <= vram_wdata;

  typedef struct {int due; int own; logic [15:0] val;} rd_t;
  rd_t         q[$];
  logic [15:0] ref_mem [int];
  logic [15:0] pool [16];
  int          total = 0, passed = 0, cyc = 0;
  bit          rr_blit = 1'b0, exp_sel = 1'b0, exp_wr = 1'b0;
  logic [15:0] exp_addr = '0, exp_wdata = '0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  // One clock cycle: drive inputs, predict grant from the priority rules, check, advance the model.
  task automatic step(input logic v, input logic [15:0] va,
                      input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                      input logic br, input logic bw, input logic [15:0] ba, input logic [15:0] bd,
                      output int g);
    int          own;
    logic        wr;
    logic [15:0] a;
    vid_sel = v; vid_addr = va;
    cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
    blit_req = br; blit_wr = bw; blit_addr = ba; blit_wdata = bd;
    if (v) g = 1;
`ifdef VRAM_ARB_RR_EN
    else if (cr && br) g = rr_blit ? 3 : 2;
`endif
    else if (cr) g = 2;
    else if (br) g = 3;
    else g = 0;
    @(negedge clk);
    chk("cpu_ack", {15'd0, cpu_ack}, {15'd0, g == 2});
    chk("blit_ack", {15'd0, blit_ack}, {15'd0, g == 3});
    own = (q.size() != 0 && q[0].due == cyc) ? q[0].own : 0;
    chk("vid_rd_valid", {15'd0, vid_rd_valid}, {15'd0, own == 1});
    chk("cpu_rd_valid", {15'd0, cpu_rd_valid}, {15'd0, own == 2});
    chk("blit_rd_valid", {15'd0, blit_rd_valid}, {15'd0, own == 3});
    if (own != 0) begin
      chk("rd_data", rd_data, q[0].val);
      void'(q.pop_front());
    end
    chk("vram_sel", {15'd0, vram_sel}, {15'd0, exp_sel});
    chk("vram_wr_en", {15'd0, vram_wr_en}, {15'd0, exp_wr});
    chk("vram_addr", vram_addr, exp_addr);
    if (exp_wr) chk("vram_wdata", vram_wdata, exp_wdata);
    wr = (g == 2 && cw) || (g == 3 && bw);
    a = g == 1 ? va : g == 2 ? ca : ba;
    exp_sel = g != 0;
    exp_wr = wr;
    if (g != 0) exp_addr = a;
    if (wr) begin
      exp_wdata = g == 2 ? cd : bd;
      ref_mem[int'(a)] = exp_wdata;
    end else if (g != 0)
      q.push_back('{cyc + 2, g, ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'hxxxx});
    if (g == 2) rr_blit = 1'b1;
    else if (g == 3) rr_blit = 1'b0;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vid_sel = 1'b0; cpu_req = 1'b0; blit_req = 1'b0;
    @(posedge clk); #1;
    cyc++;
    reset = 1'b0;
    q.delete();
    rr_blit = 1'b0; exp_sel = 1'b0; exp_wr = 1'b0; exp_addr = '0; exp_wdata = '0;
    @(negedge clk);
    chk("rst_vid_rd_valid", {15'd0, vid_rd_valid}, 16'd0);
    chk("rst_cpu_rd_valid", {15'd0, cpu_rd_valid}, 16'd0);
    chk("rst_blit_rd_valid", {15'd0, blit_rd_valid}, 16'd0);
    chk("rst_acks", {14'd0, cpu_ack, blit_ack}, 16'd0);
    chk("rst_vram_ctl", {14'd0, vram_sel, vram_wr_en}, 16'd0);
    chk("rst_vram_addr", vram_addr, 16'd0);
    chk("rst_vram_wdata", vram_wdata, 16'd0);
    chk("rst_rd_data", rd_data, 16'd0);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic cpu_op(input logic w, input logic [15:0] a, input logic [15:0] d);
    int g;
    step(0, 0, 1, w, a, d, 0, 0, 0, 0, g);
  endtask

  task automatic idle(input int n);
    int g;
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
  endtask

  initial begin
    int g;
    bit cp, bp, cpw, bpw;
    logic [15:0] cpa, cpd, bpa, bpd;
    for (int i = 0; i < 16; i++) pool[i] = 16'(i * 16'h1111);
    @(posedge clk); #1;
    do_reset();
    // basic CPU write then read
    cpu_op(1, 16'h0100, 16'h1234);
    cpu_op(0, 16'h0100, 0);
    idle(3);
    // preload the pool plus the addresses used below
    for (int i = 0; i < 16; i++) cpu_op(1, pool[i], 16'($urandom));
    cpu_op(1, 16'hA000, 16'hAAAA);
    cpu_op(1, 16'hB000, 16'hBBBB);
    // video holds the port while the CPU waits
    for (int i = 0; i < 4; i++) step(1, pool[i + 3], 1, 0, 16'h0100, 0, 0, 0, 0, 0, g);
    step(0, 0, 1, 0, 16'h0100, 0, 0, 0, 0, 0, g);
    idle(3);
    // CPU and blitter contend for 6 cycles
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 16'hA000, 0, 1, 0, 16'hB000, 0, g);
    idle(3);
    // blitter write observed by the CPU read granted after it
    step(0, 0, 0, 0, 0, 0, 1, 1, 16'h3FFF, 16'hBEEF, g);
    cpu_op(0, 16'h3FFF, 0);
    idle(3);
    // reset immediately after a read grant suppresses its return
    cpu_op(0, 16'h0100, 0);
    do_reset();
    // bank boundaries
    cpu_op(1, 16'h0000, 16'h0A0A);
    cpu_op(1, 16'h4000, 16'h4B4B);
    cpu_op(1, 16'h8000, 16'h8C8C);
    cpu_op(1, 16'hFFFF, 16'hFDFD);
    cpu_op(0, 16'h0000, 0);
    cpu_op(0, 16'h4000, 0);
    cpu_op(0, 16'h8000, 0);
    cpu_op(0, 16'hFFFF, 0);
    idle(3);
    // random traffic with request-held-until-ack discipline
    cp = 0; bp = 0; cpw = 0; bpw = 0; cpa = '0; cpd = '0; bpa = '0; bpd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!cp && $urandom_range(0, 2) == 0) begin
        cp = 1; cpw = 1'($urandom_range(0, 1)); cpa = pool[$urandom_range(0, 15)]; cpd = 16'($urandom);
      end
      if (!bp && $urandom_range(0, 2) == 0) begin
        bp = 1; bpw = 1'($urandom_range(0, 1)); bpa = pool[$urandom_range(0, 15)]; bpd = 16'($urandom);
      end
      step(1'($urandom_range(0, 4) == 0), pool[$urandom_range(0, 15)], cp, cpw, cpa, cpd, bp, bpw, bpa, bpd, g);
      if (g == 2) cp = 0;
      if (g == 3) bp = 0;
    end
    idle(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
